// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter between the I$ refill port and the D$
// refill/writeback port over one line-wide backing-memory bus. Only one line
// transaction is in flight at a time, and a watchdog bounds how long a
// grant may wait for the memory acknowledge.
module mem_arb #(
    parameter int BLK_LEN = 59,
    parameter int LINE    = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    // I$ refill port
    input  logic [BLK_LEN-1:0] b_addr_i,
    input  logic               b_rd_i,
    output logic [LINE-1:0]    b_data_i,
    output logic               b_dv_i,
    // D$ refill / writeback port
    input  logic [BLK_LEN-1:0] b_addr_d,
    input  logic               b_rd_d,
    input  logic               b_wr_d,
    input  logic [LINE-1:0]    b_wdata_d,
    output logic [LINE-1:0]    b_data_d,
    output logic               b_dv_d,
    // backing-memory bus
    output logic [BLK_LEN-1:0] m_addr,
    output logic               m_rd,
    output logic               m_wr,
    output logic [LINE-1:0]    m_wdata,
    input  logic [LINE-1:0]    m_rdata,
    input  logic               m_ack,
    // watchdog expiry
    output logic               bus_err
);

    // A TIMEOUT of 0 disables the watchdog; the counter still needs one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command registers captured at grant time; they alone drive the memory bus.
    logic [BLK_LEN-1:0] cmd_addr;
    logic               cmd_wr;
    logic [LINE-1:0]    cmd_wdata;
    logic               cmd_d;

    // Response data captured on acknowledge (zero after a watchdog expiry).
    logic [LINE-1:0]    resp_data;

    // Round-robin history: 1 when the D port was served most recently.
    logic               last_d;

    logic [CNT_W-1:0]   wd_cnt;

    logic               i_pend;
    logic               d_pend;
    logic               in_gnt;
    logic               timeout_hit;
    logic               grant_i;
    logic               grant_d;

    assign i_pend      = b_rd_i;
    assign d_pend      = b_rd_d | b_wr_d;
    assign in_gnt      = (state == GNT_I) || (state == GNT_D);
    assign timeout_hit = (TIMEOUT != 0) && in_gnt && (wd_cnt == TO_VAL);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and output decode from registered state only.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        m_addr    = '0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        m_wdata   = '0;
        bus_err   = 1'b0;
        b_dv_i    = 1'b0;
        b_dv_d    = 1'b0;
        b_data_i  = '0;
        b_data_d  = '0;
        case (state)
            IDLE: begin
                // I wins when it is the only requester or D went last.
                if (i_pend && (!d_pend || last_d)) begin
                    grant_i   = 1'b1;
                    state_nxt = GNT_I;
                end else if (d_pend) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                m_addr  = cmd_addr;
                m_wdata = cmd_wdata;
                if (timeout_hit) begin
                    bus_err   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    m_rd = ~cmd_wr;
                    m_wr = cmd_wr;
                    if (m_ack) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (cmd_d) begin
                    b_dv_d   = 1'b1;
                    b_data_d = resp_data;
                end else begin
                    b_dv_i   = 1'b1;
                    b_data_i = resp_data;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, response capture, round-robin history and watchdog count.
    // A watchdog expiry also counts as service so a dead port cannot starve
    // the other one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr  <= '0;
            cmd_wr    <= 1'b0;
            cmd_wdata <= '0;
            cmd_d     <= 1'b0;
            resp_data <= '0;
            last_d    <= 1'b1;
            wd_cnt    <= '0;
        end else if (grant_i) begin
            cmd_addr  <= b_addr_i;
            cmd_wr    <= 1'b0;
            cmd_wdata <= '0;
            cmd_d     <= 1'b0;
            wd_cnt    <= '0;
        end else if (grant_d) begin
            cmd_addr  <= b_addr_d;
            cmd_wr    <= b_wr_d;
            cmd_wdata <= b_wr_d ? b_wdata_d : '0;
            cmd_d     <= 1'b1;
            wd_cnt    <= '0;
        end else if (in_gnt) begin
            if (timeout_hit) begin
                resp_data <= '0;
                last_d    <= cmd_d;
            end else if (m_ack) begin
                resp_data <= m_rdata;
                last_d    <= cmd_d;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

endmodule
